// File: rtl/frame_pkg.sv
// Shared definitions for the frame drawing pipeline.
// Holds the sequencer state encoding, default resolution, coordinate and
// colour widths, and the pixel bundle that clear engine, sine engine and
// framebuffer all exchange.
package frame_pkg;

    localparam int unsigned COORD_W   = 8;
    localparam int unsigned COLOR_W   = 12;
    localparam int unsigned H_RES_DEF = 160;
    localparam int unsigned V_RES_DEF = 120;

    // Sequencer state encoding, exported on the phase port as-is.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CLEAR = 2'b01;
    localparam logic [1:0] ST_DRAW  = 2'b10;
    localparam logic [1:0] ST_HOLD  = 2'b11;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

endpackage

// File: rtl/pix_out_reg.sv
// One-entry valid/ready write register with on-screen clip check.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         pixel accepted from the active source this cycle
//   pix          accepted pixel
//   wr_ready     framebuffer accepts the held write
//   wr_valid     held write is valid
//   wr_pix       held write payload (stable while stalled)
//   in_range_c   combinational: pix lies inside the visible frame
module pix_out_reg
    import frame_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  pixel_t pix,
    input  logic   wr_ready,
    output logic   wr_valid,
    output pixel_t wr_pix,
    output logic   in_range_c
);

    assign in_range_c = (32'(pix.x) < H_RES) && (32'(pix.y) < V_RES);

    // Clipped pixels are consumed upstream but never occupy the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid <= 1'b0;
            wr_pix   <= '0;
        end else if (load && in_range_c) begin
            wr_valid <= 1'b1;
            wr_pix   <= pix;
        end else if (wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_draw_sequencer.sv
// Schedules the clear engine and the sine engine onto one framebuffer
// write port: CLEAR, then optionally DRAW, then a fixed HOLD per frame.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   go, mode                 frame request; mode 1 = clear only
//   clr_* / sin_*            start, valid/ready pixel stream and done of each engine
//   wr_valid/x/y/color/ready framebuffer write port
//   busy, phase              state != IDLE, raw state encoding
//   frame_done               one-cycle end-of-frame pulse
//   pix_count, clip_count    pixels written / dropped this frame, saturating
module frame_draw_sequencer
    import frame_pkg::*;
#(
    parameter int unsigned H_RES       = H_RES_DEF,
    parameter int unsigned V_RES       = V_RES_DEF,
    parameter int unsigned HOLD_CYCLES = 25000,
    parameter int unsigned PIX_W       = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               mode,
    output logic               clr_start,
    input  logic               clr_valid,
    input  logic [COORD_W-1:0] clr_x,
    input  logic [COORD_W-1:0] clr_y,
    input  logic [COLOR_W-1:0] clr_color,
    output logic               clr_ready,
    input  logic               clr_done,
    output logic               sin_start,
    input  logic               sin_valid,
    input  logic [COORD_W-1:0] sin_x,
    input  logic [COORD_W-1:0] sin_y,
    input  logic [COLOR_W-1:0] sin_color,
    output logic               sin_ready,
    input  logic               sin_done,
    output logic               wr_valid,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic [COLOR_W-1:0] wr_color,
    input  logic               wr_ready,
    output logic               busy,
    output logic [1:0]         phase,
    output logic               frame_done,
    output logic [PIX_W-1:0]   pix_count,
    output logic [7:0]         clip_count
);

    localparam int unsigned     HOLD_N    = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam int unsigned     HOLD_W    = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_N - 1);

    logic [1:0]        state, state_nx;
    logic              mode_q, mode_nx;
    logic              done_flag, done_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [PIX_W-1:0]  pix_nx;
    logic [7:0]        clip_nx;
    logic              clr_start_nx, sin_start_nx, frame_done_nx;

    pixel_t act_pix, wr_pix;
    logic   act_valid, act_done, space_c, fire, in_range_c, phase_end;

    // Route only the source owning the current phase; the other is muted.
    always_comb begin
        act_valid = 1'b0;
        act_done  = 1'b0;
        act_pix   = '0;
        if (state == ST_CLEAR) begin
            act_valid = clr_valid;
            act_done  = clr_done;
            act_pix   = {clr_x, clr_y, clr_color};
        end else if (state == ST_DRAW) begin
            act_valid = sin_valid;
            act_done  = sin_done;
            act_pix   = {sin_x, sin_y, sin_color};
        end
    end

    assign space_c   = !wr_valid || wr_ready;
    assign clr_ready = (state == ST_CLEAR) && space_c;
    assign sin_ready = (state == ST_DRAW) && space_c;
    assign fire      = act_valid && space_c;
    // A phase may only end once its last pixel has left the write stage.
    assign phase_end = done_flag && space_c;

    pix_out_reg #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (fire),
        .pix        (act_pix),
        .wr_ready   (wr_ready),
        .wr_valid   (wr_valid),
        .wr_pix     (wr_pix),
        .in_range_c (in_range_c)
    );

    assign wr_x     = wr_pix.x;
    assign wr_y     = wr_pix.y;
    assign wr_color = wr_pix.color;
    assign busy     = (state != ST_IDLE);
    assign phase    = state;

    // Next-state, counters and start/done pulses.
    always_comb begin
        state_nx      = state;
        mode_nx       = mode_q;
        done_nx       = done_flag || act_done;
        hold_nx       = hold_cnt;
        clr_start_nx  = 1'b0;
        sin_start_nx  = 1'b0;
        frame_done_nx = 1'b0;
        pix_nx        = (fire && in_range_c && (pix_count != '1))
                        ? pix_count + PIX_W'(1) : pix_count;
        clip_nx       = (fire && !in_range_c && (clip_count != '1))
                        ? clip_count + 8'(1) : clip_count;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nx     = ST_CLEAR;
                    mode_nx      = mode;
                    clr_start_nx = 1'b1;
                    done_nx      = 1'b0;
                    pix_nx       = '0;
                    clip_nx      = '0;
                end
            end
            ST_CLEAR: begin
                if (phase_end) begin
                    done_nx = 1'b0;
                    if (!mode_q) begin
                        state_nx     = ST_DRAW;
                        sin_start_nx = 1'b1;
                    end else begin
                        state_nx = ST_HOLD;
                        hold_nx  = HOLD_LOAD;
                    end
                end
            end
            ST_DRAW: begin
                if (phase_end) begin
                    done_nx  = 1'b0;
                    state_nx = ST_HOLD;
                    hold_nx  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    frame_done_nx = 1'b1;
                    if (go) begin
                        state_nx     = ST_CLEAR;
                        mode_nx      = mode;
                        clr_start_nx = 1'b1;
                        done_nx      = 1'b0;
                        pix_nx       = '0;
                        clip_nx      = '0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    hold_nx = hold_cnt - HOLD_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mode_q     <= 1'b0;
            done_flag  <= 1'b0;
            hold_cnt   <= '0;
            pix_count  <= '0;
            clip_count <= '0;
            clr_start  <= 1'b0;
            sin_start  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            mode_q     <= mode_nx;
            done_flag  <= done_nx;
            hold_cnt   <= hold_nx;
            pix_count  <= pix_nx;
            clip_count <= clip_nx;
            clr_start  <= clr_start_nx;
            sin_start  <= sin_start_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule
